// File: rtl/clause_array_ctrl.sv
// clause_array_ctrl: sequencing controller for one clause_array instance.
// Loads a bin of clauses row by row from a valid/ready stream, runs
// implication to a fixpoint, conflict or iteration limit, and issues
// backtrack pulses.
// Optional feature macro: CLAUSE_CTRL_ZERO_FILL_EN (zero-write rows after
// the last real clause of a bin).
//
// Handshake: a clause beat transfers on a rising edge where cl_valid_i and
// cl_ready_o are both high; cl_ready_o is high only in LOAD, and the beat's
// len/value/last are only looked at on that edge.
module clause_array_ctrl #(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_start_i,
  input  logic                               cl_valid_i,
  output logic                               cl_ready_o,
  input  logic [WIDTH_C_LEN-1:0]             cl_len_i,
  input  logic [NUM_VARS*3-1:0]              cl_value_i,
  input  logic                               cl_last_i,
  input  logic                               bcp_start_i,
  input  logic                               bkt_start_i,
  input  logic [NUM_VARS*3-1:0]              var_value_fb_i,
  input  logic                               conflict_i,
  output logic [NUM_CLAUSES-1:0]             wr_o,
  output logic [4:0]                         clause_len_o,
  output logic [NUM_VARS*3-1:0]              var_value_o,
  output logic                               apply_impl_o,
  output logic                               apply_bkt_o,
  output logic                               busy_o,
  output logic                               load_done_o,
  output logic                               bcp_done_o,
  output logic                               bkt_done_o,
  output logic                               bcp_conflict_o,
  output logic                               bcp_overflow_o,
  output logic [$clog2(NUM_CLAUSES):0]       rows_loaded_o,
  output logic [2:0]                         dbg_state_o
);

  localparam int PW = $clog2(NUM_CLAUSES) + 1;
  localparam int VW = NUM_VARS * 3;
  localparam int IW = $clog2(NUM_VARS + 2);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_IMPL = 3'd3;
  localparam logic [2:0] S_EVAL = 3'd4;
  localparam logic [2:0] S_BKT  = 3'd5;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] LAST_ROW = PW'(NUM_CLAUSES - 1);
  localparam logic [PW-1:0] ROWS_MAX = PW'(NUM_CLAUSES);
  localparam logic [IW-1:0] ITER_ONE = IW'(1);
  localparam logic [IW-1:0] ITER_MAX = IW'(NUM_VARS + 1);

`ifdef CLAUSE_CTRL_ZERO_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic [2:0]             r_state;
  logic [PW-1:0]          r_ptr;
  logic [PW-1:0]          r_rows;
  logic [IW-1:0]          r_iter;
  logic [VW-1:0]          r_snap;
  logic [NUM_CLAUSES-1:0] r_wr;
  logic [4:0]             r_len;
  logic [VW-1:0]          r_value;
  logic                   r_wr_last;
  logic                   r_load_done;
  logic                   r_bcp_done;
  logic                   r_bkt_done;
  logic                   r_conflict;
  logic                   r_overflow;

  logic                   w_accept;
  logic                   w_load_end;
  logic                   w_to_fill;
  logic [NUM_CLAUSES-1:0] w_row_sel;
  logic                   w_fb_same;
  logic                   w_eval_done;
  logic                   w_bcp_go;

  // Beat transfer, end-of-load and row-select decode.
  assign w_accept    = (r_state == S_LOAD) && cl_valid_i;
  assign w_load_end  = w_accept && (cl_last_i || (r_ptr == LAST_ROW));
  assign w_to_fill   = FILL_EN && (r_ptr < LAST_ROW);
  assign w_row_sel   = NUM_CLAUSES'(1) << r_ptr;
  assign w_fb_same   = (var_value_fb_i == r_snap);
  assign w_eval_done = conflict_i || w_fb_same || (r_iter >= ITER_MAX);
  assign w_bcp_go    = (r_state == S_IDLE) && !load_start_i && bcp_start_i;

  // Sequencer state, row pointer, real-row count, iteration count, snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_rows  <= '0;
      r_iter  <= '0;
      r_snap  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start_i) begin
            r_state <= S_LOAD;
            r_ptr   <= '0;
            r_rows  <= '0;
          end else if (bcp_start_i) begin
            r_state <= S_IMPL;
            r_iter  <= '0;
          end else if (bkt_start_i) begin
            r_state <= S_BKT;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_rows <= r_rows + PTR_ONE;
            if (r_ptr < ROWS_MAX) r_ptr <= r_ptr + PTR_ONE;
            if (w_load_end) r_state <= w_to_fill ? S_FILL : S_IDLE;
          end
        end
        S_FILL: begin
          if (r_ptr < ROWS_MAX) r_ptr <= r_ptr + PTR_ONE;
          if (r_ptr >= LAST_ROW) r_state <= S_IDLE;
        end
        S_IMPL: begin
          r_snap  <= var_value_fb_i;
          r_iter  <= r_iter + ITER_ONE;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_state <= w_eval_done ? S_IDLE : S_IMPL;
        end
        S_BKT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Row write register: one-hot write for exactly one cycle per row, and
  // load_done one cycle after the final row write of the bin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr        <= '0;
      r_len       <= '0;
      r_value     <= '0;
      r_wr_last   <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_wr        <= '0;
      r_wr_last   <= 1'b0;
      r_load_done <= r_wr_last;
      if (w_accept) begin
        r_wr      <= w_row_sel;
        r_len     <= 5'(cl_len_i);
        r_value   <= cl_value_i;
        r_wr_last <= w_load_end && !w_to_fill;
      end else if (r_state == S_FILL) begin
        r_wr      <= w_row_sel;
        r_len     <= '0;
        r_value   <= '0;
        r_wr_last <= (r_ptr >= LAST_ROW);
      end
    end
  end

  // Implication and backtrack completion pulses and sticky result flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcp_done <= 1'b0;
      r_bkt_done <= 1'b0;
      r_conflict <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_bcp_done <= 1'b0;
      r_bkt_done <= (r_state == S_BKT);
      if (w_bcp_go) begin
        r_conflict <= 1'b0;
        r_overflow <= 1'b0;
      end
      if ((r_state == S_EVAL) && w_eval_done) begin
        r_bcp_done <= 1'b1;
        r_conflict <= conflict_i;
        r_overflow <= !conflict_i && !w_fb_same;
      end
    end
  end

  assign cl_ready_o     = (r_state == S_LOAD);
  assign wr_o           = r_wr;
  assign clause_len_o   = r_len;
  assign var_value_o    = r_value;
  assign apply_impl_o   = (r_state == S_IMPL);
  assign apply_bkt_o    = (r_state == S_BKT);
  assign busy_o         = (r_state != S_IDLE);
  assign load_done_o    = r_load_done;
  assign bcp_done_o     = r_bcp_done;
  assign bkt_done_o     = r_bkt_done;
  assign bcp_conflict_o = r_conflict;
  assign bcp_overflow_o = r_overflow;
  assign rows_loaded_o  = r_rows;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_clause_array_ctrl.sv
// tb_clause_array_ctrl: directed bench for clause_array_ctrl. Driver tasks
// schedule, per cycle, what each output must be from the controller's rules;
// one negedge process compares the DUT against that schedule every cycle.
// A tiny array stand-in produces feedback and conflict from the number of
// implication pulses seen.
module tb_clause_array_ctrl;
  localparam int NC = 8;
  localparam int NV = 8;
  localparam int WL = 4;
  localparam int VW = NV * 3;
  localparam int RW = $clog2(NC) + 1;
  localparam int QW = NC + 5 + VW;

`ifdef CLAUSE_CTRL_ZERO_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          load_start_i = 1'b0;
  logic          cl_valid_i = 1'b0;
  logic          cl_ready_o;
  logic [WL-1:0] cl_len_i = '0;
  logic [VW-1:0] cl_value_i = '0;
  logic          cl_last_i = 1'b0;
  logic          bcp_start_i = 1'b0;
  logic          bkt_start_i = 1'b0;
  logic [VW-1:0] var_value_fb_i;
  logic          conflict_i;
  logic [NC-1:0] wr_o;
  logic [4:0]    clause_len_o;
  logic [VW-1:0] var_value_o;
  logic          apply_impl_o, apply_bkt_o, busy_o;
  logic          load_done_o, bcp_done_o, bkt_done_o;
  logic          bcp_conflict_o, bcp_overflow_o;
  logic [RW-1:0] rows_loaded_o;
  logic [2:0]    dbg_state_o;

  clause_array_ctrl #(.NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_C_LEN(WL)) dut (
    .clk(clk), .rst(rst),
    .load_start_i(load_start_i), .cl_valid_i(cl_valid_i), .cl_ready_o(cl_ready_o),
    .cl_len_i(cl_len_i), .cl_value_i(cl_value_i), .cl_last_i(cl_last_i),
    .bcp_start_i(bcp_start_i), .bkt_start_i(bkt_start_i),
    .var_value_fb_i(var_value_fb_i), .conflict_i(conflict_i),
    .wr_o(wr_o), .clause_len_o(clause_len_o), .var_value_o(var_value_o),
    .apply_impl_o(apply_impl_o), .apply_bkt_o(apply_bkt_o), .busy_o(busy_o),
    .load_done_o(load_done_o), .bcp_done_o(bcp_done_o), .bkt_done_o(bkt_done_o),
    .bcp_conflict_o(bcp_conflict_o), .bcp_overflow_o(bcp_overflow_o),
    .rows_loaded_o(rows_loaded_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- array stand-in ----------------
  int imp_cnt = 0;
  int bkt_cnt = 0;
  int imp_base = 0;
  int fix_k = 0;
  int conf_at = 0;
  int fb_p;
  always @(posedge clk) begin
    if (apply_impl_o) imp_cnt <= imp_cnt + 1;
    if (apply_bkt_o) bkt_cnt <= bkt_cnt + 1;
  end
  always_comb begin
    fb_p = imp_cnt - imp_base;
    if (fb_p > fix_k) fb_p = fix_k;
    var_value_fb_i = VW'(24'h00A5A5 + 24'(fb_p * 'h000123));
    conflict_i = (conf_at > 0) && ((imp_cnt - imp_base) >= conf_at);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [QW-1:0] exp_q[$];
  logic [NC-1:0] exp_wr[int];
  bit exp_ready[int], exp_busy[int], exp_impl[int], exp_bkt[int];
  bit exp_ldone[int], exp_bdone[int], exp_kdone[int], exp_conf[int], exp_ovf[int];
  int lens_t[NC] = '{2, 3, 3, 3, 3, 3, 4, 4};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] cval(input int i);
    return 24'h123456 ^ 24'(i * 'h0F0F01);
  endfunction

  // Per-cycle compare against the schedule.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr", wr_o, exp_wr.exists(cyc) ? exp_wr[cyc] : '0);
      chk("ready", cl_ready_o, exp_ready.exists(cyc) ? exp_ready[cyc] : 1'b0);
      chk("busy", busy_o, exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0);
      chk("apply_impl", apply_impl_o, exp_impl.exists(cyc) ? exp_impl[cyc] : 1'b0);
      chk("apply_bkt", apply_bkt_o, exp_bkt.exists(cyc) ? exp_bkt[cyc] : 1'b0);
      chk("load_done", load_done_o, exp_ldone.exists(cyc) ? exp_ldone[cyc] : 1'b0);
      chk("bcp_done", bcp_done_o, exp_bdone.exists(cyc) ? exp_bdone[cyc] : 1'b0);
      chk("bkt_done", bkt_done_o, exp_kdone.exists(cyc) ? exp_kdone[cyc] : 1'b0);
      if (exp_bdone.exists(cyc)) begin
        chk("bcp_conflict", bcp_conflict_o, exp_conf[cyc]);
        chk("bcp_overflow", bcp_overflow_o, exp_ovf[cyc]);
      end
      if (wr_o != '0) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", wr_o, '0);
        end else begin
          chk("wr_payload", {wr_o, clause_len_o, var_value_o}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load n clauses (index 0..n-1); use_last flags the n-th; alt drops valid
  // on every other LOAD cycle; race also raises bcp_start with load_start.
  task automatic do_load(input int n, input bit use_last, input bit alt, input bit race);
    int c0, c, i, fill;
    tick();
    c0 = cyc;
    load_start_i = 1'b1;
    bcp_start_i = race;
    tick();
    load_start_i = 1'b0;
    bcp_start_i = 1'b0;
    i = 0;
    forever begin
      c = cyc;
      exp_busy[c] = 1'b1;
      exp_ready[c] = 1'b1;
      if (alt && (((c - c0) % 2) == 0)) begin
        cl_valid_i = 1'b0;
        cl_last_i = 1'b0;
        cl_len_i = 4'hF;
        cl_value_i = '1;
      end else begin
        cl_valid_i = 1'b1;
        cl_len_i = WL'(lens_t[i]);
        cl_value_i = cval(i);
        cl_last_i = use_last && (i == n - 1);
        exp_wr[c + 1] = NC'(1) << i;
        exp_q.push_back({NC'(1) << i, 5'(lens_t[i]), cval(i)});
        if ((i == n - 1) || (i == NC - 1)) break;
        i++;
      end
      tick();
    end
    fill = FILL ? (NC - 1 - i) : 0;
    for (int j = 1; j <= fill; j++) begin
      exp_wr[c + 1 + j] = NC'(1) << (i + j);
      exp_q.push_back({NC'(1) << (i + j), 5'd0, {VW{1'b0}}});
      exp_busy[c + j] = 1'b1;
    end
    exp_ldone[c + 2 + fill] = 1'b1;
    tick();
    // A stray beat after the load has ended must not be taken.
    cl_valid_i = 1'b1;
    cl_last_i = 1'b0;
    cl_len_i = 4'hF;
    cl_value_i = '1;
    tick();
    cl_valid_i = 1'b0;
    repeat (fill + 3) tick();
  endtask

  // Implication run: feedback changes after pulses 1..k_fix, conflict from
  // pulse c_conf on (0 = never). poke raises load/bkt starts mid-run.
  task automatic do_bcp(input int k_fix, input int c_conf, input bit with_bkt, input bit poke);
    int s, n;
    bit cf, ov;
    tick();
    s = cyc;
    bcp_start_i = 1'b1;
    bkt_start_i = with_bkt;
    imp_base = imp_cnt;
    fix_k = k_fix;
    conf_at = c_conf;
    n = 0;
    cf = 1'b0;
    ov = 1'b0;
    for (int k = 1; k <= NV + 1; k++) begin
      if ((c_conf > 0) && (k >= c_conf)) begin cf = 1'b1; n = k; break; end
      if (k > k_fix) begin n = k; break; end
      if (k == NV + 1) begin ov = 1'b1; n = k; break; end
    end
    for (int k = 1; k <= n; k++) exp_impl[s + 2 * k - 1] = 1'b1;
    for (int k = s + 1; k <= s + 2 * n; k++) exp_busy[k] = 1'b1;
    exp_bdone[s + 2 * n + 1] = 1'b1;
    exp_conf[s + 2 * n + 1] = cf;
    exp_ovf[s + 2 * n + 1] = ov;
    tick();
    bcp_start_i = 1'b0;
    bkt_start_i = 1'b0;
    tick();
    if (poke) begin
      load_start_i = 1'b1;
      bkt_start_i = 1'b1;
    end
    tick();
    load_start_i = 1'b0;
    bkt_start_i = 1'b0;
    repeat (2 * n) tick();
  endtask

  task automatic do_bkt();
    int s;
    tick();
    s = cyc;
    bkt_start_i = 1'b1;
    exp_bkt[s + 1] = 1'b1;
    exp_busy[s + 1] = 1'b1;
    exp_kdone[s + 2] = 1'b1;
    tick();
    bkt_start_i = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0, c, base;
    repeat (2) tick();
    chk("rst_wr", wr_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", cl_ready_o, 1'b0);
    chk("rst_rows", rows_loaded_o, '0);
    chk("rst_flags", {apply_impl_o, apply_bkt_o, load_done_o, bcp_done_o, bkt_done_o,
                      bcp_conflict_o, bcp_overflow_o}, '0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Full load, with a simultaneous bcp_start that must lose to load_start.
    do_load(8, 1'b0, 1'b0, 1'b1);
    chk("rows_full", rows_loaded_o, 8);
    // Short load ending on cl_last_i.
    do_load(5, 1'b1, 1'b0, 1'b0);
    chk("rows_short", rows_loaded_o, 5);
    // Backpressure: valid toggles.
    do_load(4, 1'b1, 1'b1, 1'b0);
    chk("rows_bp", rows_loaded_o, 4);

    // Fixpoint after two pulses.
    base = imp_cnt;
    do_bcp(1, 0, 1'b0, 1'b0);
    chk("fix_pulses", imp_cnt - base, 2);
    chk("fix_conflict", bcp_conflict_o, 1'b0);
    chk("fix_overflow", bcp_overflow_o, 1'b0);
    // Conflict on first EVAL; bkt_start raised together must be ignored.
    base = imp_cnt;
    do_bcp(100, 1, 1'b1, 1'b0);
    chk("conf_pulses", imp_cnt - base, 1);
    chk("conf_bkt_ignored", bkt_cnt, 0);
    chk("conf_hold", bcp_conflict_o, 1'b1);
    // Never settles: overflow after NUM_VARS+1 pulses; starts while busy ignored.
    base = imp_cnt;
    do_bcp(100, 0, 1'b0, 1'b1);
    chk("ovf_pulses", imp_cnt - base, 9);
    chk("ovf_hold", bcp_overflow_o, 1'b1);
    chk("ovf_conf_clear", bcp_conflict_o, 1'b0);

    // Backtrack; overflow flag keeps holding across it.
    do_bkt();
    chk("bkt_pulses", bkt_cnt, 1);
    chk("ovf_hold_bkt", bcp_overflow_o, 1'b1);

    // Reset in the middle of a load after three rows.
    tick();
    c0 = cyc;
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c = cyc;
      exp_busy[c] = 1'b1;
      exp_ready[c] = 1'b1;
      cl_valid_i = 1'b1;
      cl_last_i = 1'b0;
      cl_len_i = WL'(lens_t[i]);
      cl_value_i = cval(i);
      exp_wr[c + 1] = NC'(1) << i;
      exp_q.push_back({NC'(1) << i, 5'(lens_t[i]), cval(i)});
      tick();
    end
    cl_valid_i = 1'b0;
    exp_busy[cyc] = 1'b1;
    exp_ready[cyc] = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_wr", wr_o, '0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_rows", rows_loaded_o, '0);
    chk("midrst_flags", {bcp_overflow_o, bcp_conflict_o, load_done_o}, '0);
    chk("midrst_data", {clause_len_o, var_value_o}, '0);
    tick();
    tick();
    rst = 1'b1;
    // Next load starts again at row 0.
    do_load(8, 1'b0, 1'b0, 1'b0);
    chk("rows_after_rst", rows_loaded_o, 8);

    repeat (3) tick();
    chk("writes_left", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence somehow stalls.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

endmodule
